// File: rtl/dbn_pkg.sv
// Shared DBN datapath widths and elaboration-time helpers.
// Pure constants and functions; no logic, so no latency or flow-control behaviour.
package dbn_pkg;

    localparam int DW_DEF = 16;
    localparam int PW_DEF = 2 * DW_DEF;

    // Smallest w with 2**w >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int w = 31; w >= 0; w--) begin
            if ((longint'(1) << w) >= longint'(value)) begin
                width = w;
            end
        end
        return width;
    endfunction

    function automatic int id_width(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/mult_share_arb_multi.sv
// Unsigned DW x DW multiplier core producing a full 2*DW product.
// Purely combinational; it has no handshake, so it never stalls or applies backpressure.
module multi #(
    parameter int DW = 16
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p
);

    assign p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// Round-robin grant over N requesters; search starts at ptr and wraps modulo N.
// Grant is combinational in the request cycle; ptr advances past the winner on accept.
module rr_arbiter
    import dbn_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          accept
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    logic [IW-1:0] idx;

    // Two passes emulate the wrap: indices at/after ptr first, then those before it.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IW'(i) >= ptr_q)) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IW'(i) < ptr_q)) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = found && !rst && (idx == IW'(i));
        end
        gnt_idx = idx;
        accept  = found && !rst;
        ptr_d   = ptr_q;
        if (accept) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Time-shares one multiplier among NREQ requesters; results return tagged with requester id.
// Latency MULT_LAT cycles, one accept per cycle; no response backpressure, pipeline never stalls.
module mult_share_arb
    import dbn_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DW       = DW_DEF,
    parameter  int MULT_LAT = 2,
    localparam int IDW      = id_width(NREQ),
    localparam int PW       = prod_width(DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_dataa,
    input  logic [NREQ*DW-1:0] req_datab,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [PW-1:0]    rsp_result,
    output logic             busy
);

    localparam int CW = clog2(MULT_LAT + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic [PW-1:0]  prod;
    } stage_t;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            accept;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [PW-1:0]   product;
    logic            retire;

    stage_t          stage_q [MULT_LAT];
    stage_t          stage_d [MULT_LAT];
    logic [CW-1:0]   in_flight_q;
    logic [CW-1:0]   in_flight_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .accept  (accept)
    );

    assign req_ready = gnt;

    // Grant is one-hot or zero, so an OR-reduction mux selects the winner's operands.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_a = op_a | req_dataa[i*DW +: DW];
                op_b = op_b | req_datab[i*DW +: DW];
            end
        end
    end

    multi #(
        .DW (DW)
    ) u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    always_comb begin
        stage_d[0].vld  = accept;
        stage_d[0].id   = gnt_idx;
        stage_d[0].prod = product;
        for (int s = 1; s < MULT_LAT; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MULT_LAT; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MULT_LAT; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    // A result sitting in the last stage while reset is high belongs to a flushed transaction.
    assign rsp_valid  = stage_q[MULT_LAT-1].vld & ~rst;
    assign rsp_id     = stage_q[MULT_LAT-1].id;
    assign rsp_result = stage_q[MULT_LAT-1].prod;
    assign retire     = rsp_valid;

    always_comb begin
        in_flight_d = in_flight_q + CW'(accept) - CW'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign busy = (in_flight_q != '0);

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based model of grants, results and occupancy.
module tb_mult_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_dataa;
    logic [NREQ*DW-1:0]   req_datab;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [2*DW-1:0]      rsp_result;
    logic                 busy;

    mult_share_arb #(
        .NREQ     (NREQ),
        .DW       (DW),
        .MULT_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: outstanding products in acceptance order, each with the cycle it must appear.
    typedef struct {
        int              due;
        int              id;
        logic [2*DW-1:0] prod;
    } pend_t;

    pend_t           pend[$];
    int              mptr = 0;
    int              g;
    logic [NREQ-1:0] e_ready;
    logic            e_vld;
    logic [IDW-1:0]  e_id;
    logic [2*DW-1:0] e_res;
    logic            e_busy;

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i]          = 1'b1;
        req_dataa[i*DW +: DW] = a;
        req_datab[i*DW +: DW] = b;
    endtask

    // Moves to mid-cycle and derives this cycle's expected outputs from the model.
    task automatic tick();
        @(negedge clk);
        e_busy = (pend.size() != 0);
        e_vld  = 1'b0;
        e_id   = '0;
        e_res  = '0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            e_vld = !rst;
            e_id  = IDW'(pend[0].id);
            e_res = pend[0].prod;
        end
        e_ready = '0;
        g       = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
        end
        if (g >= 0) e_ready[g] = 1'b1;
    endtask

    // Applies this cycle's transfer/retire/reset to the model, then crosses the clock edge.
    task automatic advance();
        logic [2*DW-1:0] pa;
        logic [2*DW-1:0] pb;
        if (rst) begin
            pend.delete();
            mptr = 0;
        end else begin
            if (pend.size() != 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (g >= 0) begin
                pa = {{DW{1'b0}}, req_dataa[g*DW +: DW]};
                pb = {{DW{1'b0}}, req_datab[g*DW +: DW]};
                pend.push_back('{due: cyc + LAT, id: g, prod: pa * pb});
                mptr = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d ready=%b (want 0000) rsp_valid=%b (want 0)", k, req_ready, rsp_valid);
            end
            advance();
        end
        rst       = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
                rsp_result !== 32'h0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d ready=%b vld=%b id=%0d res=%h busy=%b (want all 0)",
                         k, req_ready, rsp_valid, rsp_id, rsp_result, busy);
            end
            advance();
        end
    endtask

    task automatic test_single();
        req_valid = '0;
        set_req(2, 16'h0003, 16'h0007);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (req_ready !== ((k == 0) ? 4'b0100 : 4'b0000) || rsp_valid !== (k == 2) ||
                busy !== (k == 1 || k == 2) ||
                (k == 2 && (rsp_id !== 2'd2 || rsp_result !== 32'h0000_0015))) begin
                n_fail++;
                $display("FAIL single k=%0d ready=%b vld=%b id=%0d res=%h busy=%b",
                         k, req_ready, rsp_valid, rsp_id, rsp_result, busy);
            end
            advance();
            req_valid = '0;
        end
    endtask

    task automatic test_all_rr();
        logic [NREQ-1:0] exp_g;
        do_reset(1);
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'h0010);
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_g = 4'b0001 << (k % NREQ);
            n_tests++;
            if (req_ready !== exp_g || rsp_valid !== (k >= 2) || busy !== (k >= 1) ||
                (k >= 2 && (rsp_id !== IDW'((k - 2) % NREQ) ||
                            rsp_result !== 32'(((k - 2) % NREQ + 1) * 16)))) begin
                n_fail++;
                $display("FAIL all_rr k=%0d ready=%b want %b vld=%b id=%0d res=%h busy=%b",
                         k, req_ready, exp_g, rsp_valid, rsp_id, rsp_result, busy);
            end
            advance();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (req_ready !== e_ready || rsp_valid !== e_vld || busy !== e_busy ||
                (e_vld && (rsp_id !== e_id || rsp_result !== e_res))) begin
                n_fail++;
                $display("FAIL all_rr_drain cyc=%0d ready=%b/%b vld=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b",
                         cyc, req_ready, e_ready, rsp_valid, e_vld, rsp_id, e_id, rsp_result, e_res, busy, e_busy);
            end
            advance();
        end
    endtask

    task automatic test_boundary();
        logic [IDW-1:0]  cid  [3] = '{2'd1, 2'd0, 2'd3};
        logic [2*DW-1:0] cres [3] = '{32'hFFFE_0001, 32'h0001_0000, 32'h0000_0000};
        for (int k = 0; k < 6; k++) begin
            req_valid = '0;
            case (k)
                0: set_req(1, 16'hFFFF, 16'hFFFF);
                1: set_req(0, 16'h8000, 16'h0002);
                2: set_req(3, 16'h1234, 16'h0000);
                default: ;
            endcase
            tick();
            n_tests++;
            if (req_ready !== e_ready || rsp_valid !== (k >= 2 && k <= 4) || busy !== e_busy ||
                (k >= 2 && k <= 4 && (rsp_id !== cid[k-2] || rsp_result !== cres[k-2]))) begin
                n_fail++;
                $display("FAIL boundary k=%0d ready=%b/%b vld=%b id=%0d res=%h busy=%b/%b",
                         k, req_ready, e_ready, rsp_valid, rsp_id, rsp_result, busy, e_busy);
            end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] cgnt [3] = '{4'b1000, 4'b0001, 4'b1000};
        for (int k = 0; k < 6; k++) begin
            req_valid = '0;
            if (k <= 2) set_req(3, 16'h0002, 16'h0003);
            if (k == 1 || k == 2) set_req(0, 16'h0004, 16'h0005);
            tick();
            n_tests++;
            if ((k <= 2 && req_ready !== cgnt[k]) || req_ready !== e_ready || rsp_valid !== e_vld ||
                busy !== e_busy || (e_vld && (rsp_id !== e_id || rsp_result !== e_res))) begin
                n_fail++;
                $display("FAIL wrap k=%0d ready=%b/%b vld=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b",
                         k, req_ready, e_ready, rsp_valid, e_vld, rsp_id, e_id, rsp_result, e_res, busy, e_busy);
            end
            advance();
        end
        req_valid = '0;
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int              wait_cnt [NREQ];
        logic [NREQ-1:0] gnt_obs;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        req_valid = '0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 55) set_req(i, pick_operand(), pick_operand());
            end
            tick();
            gnt_obs = req_ready;
            n_tests++;
            if (req_ready !== e_ready || rsp_valid !== e_vld || busy !== e_busy ||
                (e_vld && (rsp_id !== e_id || rsp_result !== e_res))) begin
                n_fail++;
                $display("FAIL random cyc=%0d ready=%b/%b vld=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b",
                         cyc, req_ready, e_ready, rsp_valid, e_vld, rsp_id, e_id, rsp_result, e_res, busy, e_busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_obs[i] === 1'b1) begin
                    n_tests++;
                    if (wait_cnt[i] > NREQ - 1) begin
                        n_fail++;
                        $display("FAIL fairness cyc=%0d req=%0d waited %0d cycles (limit %0d)",
                                 cyc, i, wait_cnt[i], NREQ - 1);
                    end
                end
            end
            advance();
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_obs[i] === 1'b1) begin
                    req_valid[i] = 1'b0;
                    wait_cnt[i]  = 0;
                end else if (req_valid[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (rsp_valid !== e_vld || busy !== e_busy || (e_vld && (rsp_id !== e_id || rsp_result !== e_res))) begin
                n_fail++;
                $display("FAIL random_drain cyc=%0d vld=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b",
                         cyc, rsp_valid, e_vld, rsp_id, e_id, rsp_result, e_res, busy, e_busy);
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        logic [NREQ-1:0] exp_r;
        for (int k = 0; k < 12; k++) begin
            req_valid = '0;
            rst       = (k == 2);
            if (k == 0) set_req(1, 16'h0011, 16'h0003);
            if (k == 1) set_req(2, 16'h0022, 16'h0004);
            if (k == 8) set_req(0, 16'h0005, 16'h0006);
            tick();
            exp_r = (k == 0) ? 4'b0010 : (k == 1) ? 4'b0100 : (k == 8) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (req_ready !== exp_r || rsp_valid !== (k == 10) ||
                busy !== (k == 1 || k == 2 || k == 9 || k == 10) ||
                (k == 10 && (rsp_id !== 2'd0 || rsp_result !== 32'h0000_001E)) ||
                req_ready !== e_ready || rsp_valid !== e_vld || busy !== e_busy) begin
                n_fail++;
                $display("FAIL reset_midflight k=%0d ready=%b want %b vld=%b id=%0d res=%h busy=%b",
                         k, req_ready, exp_r, rsp_valid, rsp_id, rsp_result, busy);
            end
            advance();
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dataa = '0;
        req_datab = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_rr();
        test_boundary();
        test_wrap();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
